// File: rtl/mul8_sched_pkg.sv
// mul8_sched_pkg
// Shared definitions for the time-shared 8x8 multiplier:
//   - NIB       : nibble width of the shared partial-product multiplier
//   - state_e   : controller states (IDLE, four accumulate phases, DONE)
//   - SH_P0..P3 : left-shift applied to each phase's nibble product
package mul8_sched_pkg;

    localparam int NIB = 4;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_P0   = 3'd1,
        ST_P1   = 3'd2,
        ST_P2   = 3'd3,
        ST_P3   = 3'd4,
        ST_DONE = 3'd5
    } state_e;

    // Weight of each partial product: lo*lo, hi*lo, lo*hi, hi*hi.
    localparam int SH_P0 = 0;
    localparam int SH_P1 = 4;
    localparam int SH_P2 = 4;
    localparam int SH_P3 = 8;

endpackage

// File: rtl/mul8_sched_array4.sv
// array4
// Purely combinational 4x4 unsigned array multiplier.
// Ports:
//   x : multiplicand nibble (unsigned)
//   y : multiplier nibble (unsigned)
//   p : 8-bit unsigned product x*y
module array4
    import mul8_sched_pkg::*;
(
    input  logic [NIB-1:0]   x,
    input  logic [NIB-1:0]   y,
    output logic [2*NIB-1:0] p
);

    // One shifted row of x per bit of y; the rows are then summed.
    logic [2*NIB-1:0] rows [NIB];

    genvar gi;
    generate
        for (gi = 0; gi < NIB; gi++) begin : g_row
            assign rows[gi] = y[gi] ? ({{NIB{1'b0}}, x} << gi) : '0;
        end
    endgenerate

    // The product of two NIB-bit values always fits in 2*NIB bits,
    // so dropping the carry of this sum is safe.
    always_comb begin
        p = '0;
        for (int i = 0; i < NIB; i++) begin
            p = p + rows[i];
        end
    end

endmodule

// File: rtl/mul8_sched.sv
// mul8_sched
// 8x8 unsigned multiplier that reuses a single 4x4 multiplier over four
// cycles, accumulating the shifted nibble products into a 16-bit register.
// Ports:
//   clk       : clock, all state changes on the rising edge
//   rst       : synchronous active-high reset
//   in_valid  : operand pair a/b presented
//   in_ready  : high only in IDLE; accept = in_valid && in_ready
//   a, b      : unsigned operands, captured on accept
//   out_valid : high in DONE, product on c
//   out_ready : consumer takes product; DONE -> IDLE
//   c         : product (accumulator), holds last product while IDLE
//   busy      : high in any state other than IDLE
module mul8_sched #(
    parameter int W   = 8,
    parameter int NIB = W / 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*W-1:0] c,
    output logic           busy
);

    import mul8_sched_pkg::*;

    state_e         state_q, state_d;
    logic [W-1:0]   a_q, a_d;
    logic [W-1:0]   b_q, b_d;
    logic [2*W-1:0] acc_q, acc_d;

    logic [NIB-1:0]   nib_a, nib_b;
    logic [2*NIB-1:0] nib_prod;
    logic [3:0]       shamt;
    logic [2*W-1:0]   pp_shifted;

    // Operand nibble and weight selection for the current phase. Outside
    // the accumulate phases the selection is don't-care; P0's choice is
    // used so the mux stays simple.
    always_comb begin
        nib_a = a_q[NIB-1:0];
        nib_b = b_q[NIB-1:0];
        shamt = 4'(SH_P0);
        case (state_q)
            ST_P1: begin
                nib_a = a_q[W-1:NIB];
                nib_b = b_q[NIB-1:0];
                shamt = 4'(SH_P1);
            end
            ST_P2: begin
                nib_a = a_q[NIB-1:0];
                nib_b = b_q[W-1:NIB];
                shamt = 4'(SH_P2);
            end
            ST_P3: begin
                nib_a = a_q[W-1:NIB];
                nib_b = b_q[W-1:NIB];
                shamt = 4'(SH_P3);
            end
            default: begin
                nib_a = a_q[NIB-1:0];
                nib_b = b_q[NIB-1:0];
                shamt = 4'(SH_P0);
            end
        endcase
    end

    array4 u_array4 (
        .x (nib_a),
        .y (nib_b),
        .p (nib_prod)
    );

    assign pp_shifted = {{W{1'b0}}, nib_prod} << shamt;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    acc_d   = '0;
                    state_d = ST_P0;
                end
            end
            ST_P0: begin
                acc_d   = acc_q + pp_shifted;
                state_d = ST_P1;
            end
            ST_P1: begin
                acc_d   = acc_q + pp_shifted;
                state_d = ST_P2;
            end
            ST_P2: begin
                acc_d   = acc_q + pp_shifted;
                state_d = ST_P3;
            end
            ST_P3: begin
                // Largest possible sum is 0xFE01, so 16 bits never overflow.
                acc_d   = acc_q + pp_shifted;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                // Return to IDLE only; a new accept needs a separate cycle.
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q != ST_IDLE);
    assign c         = acc_q;

endmodule

// File: tb/tb_mul8_sched.sv
module tb_mul8_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] c;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mul8_sched #(.W(8), .NIB(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .c         (c),
        .busy      (busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference product: plain unsigned arithmetic.
    function automatic logic [15:0] ref_mul(input logic [7:0] x, input logic [7:0] y);
        return 16'(x) * 16'(y);
    endfunction

    // Presents one operand pair, then counts edges until out_valid (bounded).
    task automatic run_op(input logic [7:0] oa, input logic [7:0] ob,
                          output logic [15:0] got, output int lat);
        int w;
        w = 0;
        while (!in_ready && w < 20) begin
            tick();
            w++;
        end
        in_valid = 1'b1;
        a        = oa;
        b        = ob;
        tick();
        in_valid = 1'b0;
        a        = 8'($urandom);
        b        = 8'($urandom);
        lat      = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        got = c;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 1'b1;
        a         = 8'hFF;
        b         = 8'hFF;
        out_ready = 1'b0;
        tick();
        tick();
        rst      = 1'b0;
        in_valid = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_busy got=%0b exp=0", busy);
        end
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_out_valid got=%0b exp=0", out_valid);
        end
        checks++;
        if (c !== 16'h0000) begin
            failures++;
            $display("FAIL reset_c got=%h exp=0000", c);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_in_ready got=%0b exp=1", in_ready);
        end
        $display("reset: busy=%0b out_valid=%0b c=%h in_ready=%0b", busy, out_valid, c, in_ready);
    endtask

    task automatic test_vectors();
        logic [7:0]  va [12];
        logic [7:0]  vb [12];
        logic [15:0] got;
        logic [15:0] exp;
        int          lat;
        va[0] = 8'h12; vb[0] = 8'h34;
        va[1] = 8'hA5; vb[1] = 8'h5A;
        va[2] = 8'h00; vb[2] = 8'hFF;
        va[3] = 8'hFF; vb[3] = 8'hFF;
        for (int i = 4; i < 12; i++) begin
            va[i] = 8'($urandom);
            vb[i] = 8'($urandom);
        end
        for (int i = 0; i < 12; i++) begin
            exp = ref_mul(va[i], vb[i]);
            run_op(va[i], vb[i], got, lat);
            checks++;
            if (lat !== 4) begin
                failures++;
                $display("FAIL latency a=%h b=%h got=%0d exp=4", va[i], vb[i], lat);
            end
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL product a=%h b=%h got=%h exp=%h", va[i], vb[i], got, exp);
            end
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
            checks++;
            if (out_valid !== 1'b0) begin
                failures++;
                $display("FAIL valid_one_cycle a=%h b=%h got=%0b exp=0", va[i], vb[i], out_valid);
            end
            checks++;
            if (c !== exp || in_ready !== 1'b1) begin
                failures++;
                $display("FAIL idle_hold a=%h b=%h c=%h exp=%h in_ready=%0b", va[i], vb[i], c, exp, in_ready);
            end
            $display("op: a=%h b=%h c=%h exp=%h lat=%0d", va[i], vb[i], got, exp, lat);
        end
    endtask

    task automatic test_stall();
        logic [15:0] got;
        int          lat;
        run_op(8'h12, 8'h34, got, lat);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (out_valid !== 1'b1 || c !== 16'h03A8 || in_ready !== 1'b0) begin
                failures++;
                $display("FAIL stall cyc=%0d out_valid=%0b c=%h in_ready=%0b exp 1/03a8/0", i, out_valid, c, in_ready);
            end
            tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL stall_release got=%0b exp=0", out_valid);
        end
        $display("stall: c=%h held 3 cycles", c);
    endtask

    task automatic test_ignore_in_valid();
        int w;
        in_valid = 1'b1;
        a        = 8'h12;
        b        = 8'h34;
        tick();                 // accept; now in P0
        in_valid = 1'b0;
        tick();                 // now in P1
        in_valid = 1'b1;
        a        = 8'h77;
        b        = 8'($urandom);
        tick();
        in_valid = 1'b0;
        w = 0;
        while (!out_valid && w < 20) begin
            tick();
            w++;
        end
        checks++;
        if (out_valid !== 1'b1 || c !== 16'h03A8) begin
            failures++;
            $display("FAIL ignore_in_valid out_valid=%0b c=%h exp=03a8", out_valid, c);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        $display("ignore_in_valid: c=%h", c);
    endtask

    task automatic test_reset_mid();
        logic [15:0] got;
        int          lat;
        in_valid = 1'b1;
        a        = 8'h12;
        b        = 8'h34;
        tick();                 // P0
        in_valid = 1'b0;
        tick();                 // P1
        tick();                 // P2
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || c !== 16'h0000 || busy !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid out_valid=%0b c=%h busy=%0b in_ready=%0b exp 0/0000/0/1", out_valid, c, busy, in_ready);
        end
        run_op(8'h0F, 8'h10, got, lat);
        checks++;
        if (got !== 16'h00F0 || lat !== 4) begin
            failures++;
            $display("FAIL after_reset_op got=%h lat=%0d exp=00f0 lat=4", got, lat);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        $display("reset_mid: post-reset product c=%h", got);
    endtask

    task automatic test_back_to_back();
        logic [15:0] exp_q [$];
        logic [15:0] exp;
        int          last_acc;
        int          accepts;
        int          results;
        logic        acc_now;
        logic        done_now;
        last_acc  = -1;
        accepts   = 0;
        results   = 0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        a         = 8'($urandom);
        b         = 8'($urandom);
        for (int cyc = 0; cyc < 80; cyc++) begin
            if (cyc == 60) in_valid = 1'b0;
            acc_now  = in_valid && in_ready;
            done_now = out_valid && out_ready;
            if (done_now) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL b2b_spurious cyc=%0d c=%h", cyc, c);
                end else begin
                    exp = exp_q.pop_front();
                    if (c !== exp) begin
                        failures++;
                        $display("FAIL b2b_product cyc=%0d got=%h exp=%h", cyc, c, exp);
                    end
                    $display("b2b result: cyc=%0d c=%h exp=%h", cyc, c, exp);
                end
                results++;
            end
            if (acc_now) begin
                exp_q.push_back(ref_mul(a, b));
                if (last_acc >= 0) begin
                    checks++;
                    if (cyc - last_acc !== 6) begin
                        failures++;
                        $display("FAIL b2b_spacing cyc=%0d got=%0d exp=6", cyc, cyc - last_acc);
                    end
                end
                last_acc = cyc;
                accepts++;
            end
            tick();
            a = 8'($urandom);
            b = 8'($urandom);
        end
        out_ready = 1'b0;
        checks++;
        if (accepts !== 10 || results !== accepts || exp_q.size() != 0) begin
            failures++;
            $display("FAIL b2b_count accepts=%0d results=%0d pending=%0d exp 10/10/0", accepts, results, exp_q.size());
        end
        $display("b2b: accepts=%0d results=%0d", accepts, results);
    endtask

    initial begin
        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = 8'h00;
        b         = 8'h00;
        test_reset();
        test_vectors();
        test_stall();
        test_ignore_in_valid();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
